// File: rtl/ptw_mem_arbiter.sv
// Shares one memory read port between the IFU and LSU page-table walkers (round-robin, grant locked to completion).
// Latency: mem_req_o one cycle after a request is seen in IDLE; rvalid_o one cycle after mem_rvalid_i or timeout.
// Backpressure: mem_req_o/mem_addr_o held until mem_ready_i; walkers hold req level until their rvalid pulse.
module ptw_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic [AW-1:0] ls_addr_i,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ready_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic          owner_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          r_rr_last;
  logic [AW-1:0] r_addr;
  logic [TW-1:0] r_cnt;
  logic          r_if_rvalid;
  logic          r_ls_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_ls_rdata;

  logic          w_grant;        // latch a new owner/address this cycle
  logic          w_grant_ls;     // arbitration result: 1 = LSU wins
  logic          w_accept;       // memory took the request
  logic          w_deliver;      // send a response to the owner
  logic [DW-1:0] w_deliver_dat;
  logic          w_tmo;          // this is the last allowed WAIT cycle

  // Sole requester wins; on a tie the walker not served last time wins.
  assign w_grant_ls = ls_req_i & (~if_req_i | ~r_rr_last);

  // The counter holds the number of WAIT cycles already completed, so the
  // timeout fires at the end of WAIT cycle TMO_CYC.
  assign w_tmo = (r_cnt == TW'(TMO_CYC - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes; flush overrides any response or timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_accept      = 1'b0;
    w_deliver     = 1'b0;
    w_deliver_dat = '0;
    case (r_state)
      S_IDLE: begin
        if (if_req_i || ls_req_i) begin
          w_grant     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = flush_i ? S_DROP : S_WAIT;
        end else if (flush_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          // A response arriving with the flush is consumed silently.
          w_state_nxt = mem_rvalid_i ? S_IDLE : S_DROP;
        end else if (mem_rvalid_i) begin
          w_deliver     = 1'b1;
          w_deliver_dat = mem_rdata_i;
          w_state_nxt   = S_IDLE;
        end else if (w_tmo) begin
          // PTE of zero has V=0, so the walker takes its page-fault path.
          w_deliver     = 1'b1;
          w_state_nxt   = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_rvalid_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant bookkeeping: owner and address are frozen for the whole grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_rr_last <= 1'b1;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_ls;
        r_addr  <= w_grant_ls ? ls_addr_i : if_addr_i;
      end
      if (w_accept) begin
        r_rr_last <= r_owner;
      end
    end
  end

  // Timeout counter: cleared on acceptance, counts every cycle spent in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response routing: only the owner sees a pulse; data held between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_deliver & ~r_owner;
      r_ls_rvalid <= w_deliver & r_owner;
      if (w_deliver && !r_owner) begin
        r_if_rdata <= w_deliver_dat;
      end
      if (w_deliver && r_owner) begin
        r_ls_rdata <= w_deliver_dat;
      end
    end
  end

  assign mem_req_o   = (r_state == S_REQ);
  assign mem_addr_o  = r_addr;
  assign busy_o      = (r_state != S_IDLE);
  assign owner_o     = r_owner;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_rdata_o  = r_ls_rdata;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter with a 4-cycle timeout.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Memory side is driven by hand: ready/rvalid timing is spelled out step by step.
module tb_ptw_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        owner_o;

  int checks;
  int errors;

  ptw_mem_arbiter #(
    .AW(32), .DW(32), .TMO_CYC(4), .TW(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in a REQ cycle: accept now, return data on the first WAIT cycle.
  task automatic complete(input logic [31:0] d);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_addr_i = 32'h0;
    flush_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_if_rvalid", if_rvalid_o, 0);
    chk("rst_ls_rvalid", ls_rvalid_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    rst = 1'b0;

    // 1. Single IFU read: ready at +2, rvalid at +5
    if_req_i = 1'b1; if_addr_i = 32'h8000_1000;
    chk("t1_req_c0", mem_req_o, 0);
    tick();
    chk("t1_req_c1", mem_req_o, 1);
    chk("t1_addr_c1", mem_addr_o, 32'h8000_1000);
    chk("t1_busy_c1", busy_o, 1);
    chk("t1_owner", owner_o, 0);
    if_addr_i = 32'hFFFF_FFFF;
    tick();
    chk("t1_req_c2", mem_req_o, 1);
    chk("t1_addr_stable", mem_addr_o, 32'h8000_1000);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    chk("t1_req_c3", mem_req_o, 0);
    chk("t1_busy_c3", busy_o, 1);
    tick();
    tick();
    chk("t1_no_early_rvalid", if_rvalid_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t1_if_rvalid", if_rvalid_o, 1);
    chk("t1_if_rdata", if_rdata_o, 32'h2000_00CF);
    chk("t1_ls_rvalid", ls_rvalid_o, 0);
    chk("t1_busy_done", busy_o, 0);
    if_req_i = 1'b0;
    tick();
    chk("t1_if_rvalid_pulse", if_rvalid_o, 0);
    chk("t1_idle", busy_o, 0);

    // 2. Round-robin ties (fresh reset so the first tie goes to IFU)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_1A00;
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_2B00;
    tick();
    chk("t2_tie1_owner", owner_o, 0);
    chk("t2_tie1_addr", mem_addr_o, 32'h0000_1A00);
    complete(32'h1111_0001);
    chk("t2_tie1_if_rvalid", if_rvalid_o, 1);
    chk("t2_tie1_if_rdata", if_rdata_o, 32'h1111_0001);
    chk("t2_tie1_ls_quiet", ls_rvalid_o, 0);
    chk("t2_bubble", busy_o, 0);
    if_req_i = 1'b0;
    tick();
    chk("t2_ls_owner", owner_o, 1);
    chk("t2_ls_addr", mem_addr_o, 32'h0000_2B00);
    complete(32'h2222_0002);
    chk("t2_ls_rvalid", ls_rvalid_o, 1);
    chk("t2_ls_rdata", ls_rdata_o, 32'h2222_0002);
    chk("t2_if_quiet", if_rvalid_o, 0);
    chk("t2_if_rdata_held", if_rdata_o, 32'h1111_0001);
    if_req_i = 1'b1; if_addr_i = 32'h0000_3C00;
    tick();
    chk("t2_tie2_owner", owner_o, 0);
    chk("t2_tie2_addr", mem_addr_o, 32'h0000_3C00);
    complete(32'h3333_0003);
    chk("t2_tie2_if_rdata", if_rdata_o, 32'h3333_0003);
    if_req_i = 1'b0;
    tick();
    chk("t2_tie2_ls_owner", owner_o, 1);
    complete(32'h4444_0004);
    chk("t2_tie2_ls_rdata", ls_rdata_o, 32'h4444_0004);
    ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_4D00;
    tick();
    chk("t2_solo_if_owner", owner_o, 0);
    complete(32'h5555_0005);
    chk("t2_solo_if_rdata", if_rdata_o, 32'h5555_0005);
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_5E00;
    tick();
    chk("t2_tie3_owner", owner_o, 1);
    chk("t2_tie3_addr", mem_addr_o, 32'h0000_5E00);
    complete(32'h6666_0006);
    chk("t2_tie3_ls_rvalid", ls_rvalid_o, 1);
    chk("t2_tie3_if_quiet", if_rvalid_o, 0);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    tick();
    chk("t2_idle", busy_o, 0);

    // 3. Flush in WAIT for an LSU grant; late rvalid discarded
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_7000;
    tick();
    chk("t3_owner", owner_o, 1);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; ls_req_i = 1'b0;
    chk("t3_drop_busy", busy_o, 1);
    chk("t3_drop_ls_rvalid", ls_rvalid_o, 0);
    tick();
    tick();
    chk("t3_busy_before_rvalid", busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t3_no_ls_rvalid", ls_rvalid_o, 0);
    chk("t3_busy_clear", busy_o, 0);
    chk("t3_ls_rdata_held", ls_rdata_o, 32'h6666_0006);
    if_req_i = 1'b1; if_addr_i = 32'h0000_8000;
    tick();
    chk("t3_if_owner", owner_o, 0);
    chk("t3_if_addr", mem_addr_o, 32'h0000_8000);
    if_req_i = 1'b0; if_addr_i = 32'hFFFF_0000;
    complete(32'h7777_0007);
    chk("t3_if_rvalid", if_rvalid_o, 1);
    chk("t3_if_rdata", if_rdata_o, 32'h7777_0007);

    // 4. Timeout after 4 WAIT cycles, then late rvalid dropped
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_9000;
    tick();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    chk("t4_w1_rvalid", ls_rvalid_o, 0);
    tick();
    tick();
    tick();
    chk("t4_w4_rvalid", ls_rvalid_o, 0);
    chk("t4_w4_busy", busy_o, 1);
    tick();
    chk("t4_tmo_rvalid", ls_rvalid_o, 1);
    chk("t4_tmo_rdata", ls_rdata_o, 0);
    chk("t4_tmo_if_quiet", if_rvalid_o, 0);
    chk("t4_tmo_busy", busy_o, 1);
    ls_req_i = 1'b0;
    tick();
    chk("t4_tmo_pulse", ls_rvalid_o, 0);
    chk("t4_drop_busy", busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t4_late_dropped", ls_rvalid_o, 0);
    chk("t4_late_rdata", ls_rdata_o, 0);
    chk("t4_idle", busy_o, 0);

    // 5. Asynchronous reset while in REQ
    if_req_i = 1'b1; if_addr_i = 32'h0000_A000;
    tick();
    chk("t5_req_before", mem_req_o, 1);
    rst = 1'b1;
    #1;
    chk("t5_mem_req", mem_req_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_if_rvalid", if_rvalid_o, 0);
    chk("t5_ls_rvalid", ls_rvalid_o, 0);
    chk("t5_addr", mem_addr_o, 0);
    if_req_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("t5_stay_idle", busy_o, 0);

    // 6. Flush with ready in REQ -> DROP; also flush cases without a response
    if_req_i = 1'b1; if_addr_i = 32'h0000_B000;
    tick();
    mem_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    mem_ready_i = 1'b0; flush_i = 1'b0; if_req_i = 1'b0;
    chk("t6_drop_req", mem_req_o, 0);
    chk("t6_drop_busy", busy_o, 1);
    tick();
    chk("t6_drop_hold", busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t6_no_if_rvalid", if_rvalid_o, 0);
    chk("t6_if_rdata", if_rdata_o, 0);
    chk("t6_idle", busy_o, 0);
    if_req_i = 1'b1;
    tick();
    flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("t6_req_flush_mem_req", mem_req_o, 0);
    chk("t6_req_flush_busy", busy_o, 0);
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_C000;
    tick();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0; ls_req_i = 1'b0;
    flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    flush_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t6_wait_flush_rvalid", ls_rvalid_o, 0);
    chk("t6_wait_flush_busy", busy_o, 0);
    chk("t6_wait_flush_rdata", ls_rdata_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
